mult_controller: RTL and testbench

MULT_CONTROLLER -- requirements
Module: mult_controller

---
 rtl/mult_controller_pkg.sv | 33 +++
 rtl/mult_controller.sv | 97 +++++++++
 tb/tb_mult_controller.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_controller_pkg.sv
// Shared definitions for the multiplier controller: state encoding and the
// bundle of datapath control strobes it drives.
package mult_controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    NORM1 = 3'd2,
    NORM2 = 3'd3,
    MULT  = 3'd4,
    SHIFT = 3'd5,
    WRITE = 3'd6,
    DONE  = 3'd7
  } state_t;

  typedef struct packed {
    logic ld1;
    logic ld2;
    logic ld3;
    logic shl1;
    logic shl2;
    logic shl3;
    logic cnt1;
    logic cnt2;
    logic clrCntr;
    logic wr;
    logic busy;
    logic done;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mult_controller.sv
// Sequencer for the normalise-multiply-write datapath: walks every operand
// pair in the RAM, normalising both operands before each product is formed.
module mult_controller
  import mult_controller_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic msb1,
  input  logic msb2,
  input  logic co1,
  input  logic co2,
  input  logic co3,
  output logic ld1,
  output logic ld2,
  output logic ld3,
  output logic shl1,
  output logic shl2,
  output logic shl3,
  output logic cnt1,
  output logic cnt2,
  output logic clr_cntr,
  output logic wr,
  output logic busy,
  output logic done
);

  state_t r_state;
  state_t w_nextState;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Strobes are gated by rst so the datapath sees no activity while reset is held.
  always_comb begin
    w_nextState = r_state;
    w_ctrl      = CTRL_NONE;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (start) w_nextState = LOAD;
        end
        LOAD: begin
          w_ctrl.ld1     = 1'b1;
          w_ctrl.ld2     = 1'b1;
          w_ctrl.clrCntr = 1'b1;
          w_nextState    = NORM1;
        end
        NORM1: begin
          if (!msb1 && !co3) w_ctrl.shl1 = 1'b1;
          else               w_nextState = NORM2;
        end
        NORM2: begin
          if (!msb2 && !co3) w_ctrl.shl2 = 1'b1;
          else               w_nextState = MULT;
        end
        MULT: begin
          w_ctrl.ld3  = 1'b1;
          w_nextState = SHIFT;
        end
        SHIFT: begin
          w_ctrl.shl3 = 1'b1;
          w_ctrl.cnt2 = 1'b1;
          if (co2) w_nextState = WRITE;
        end
        WRITE: begin
          w_ctrl.wr   = 1'b1;
          w_ctrl.cnt1 = 1'b1;
          w_nextState = co1 ? DONE : LOAD;
        end
        DONE: begin
          w_ctrl.done = 1'b1;
          w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
      w_ctrl.busy = (r_state != IDLE);
    end
  end

  assign ld1      = w_ctrl.ld1;
  assign ld2      = w_ctrl.ld2;
  assign ld3      = w_ctrl.ld3;
  assign shl1     = w_ctrl.shl1;
  assign shl2     = w_ctrl.shl2;
  assign shl3     = w_ctrl.shl3;
  assign cnt1     = w_ctrl.cnt1;
  assign cnt2     = w_ctrl.cnt2;
  assign clr_cntr = w_ctrl.clrCntr;
  assign wr       = w_ctrl.wr;
  assign busy     = w_ctrl.busy;
  assign done     = w_ctrl.done;

endmodule

// File: tb/tb_mult_controller.sv
// Self-checking bench for mult_controller: per-cycle vector table, then whole
// runs against a stand-in datapath scored by a closed-form latency/count model.
module tb_mult_controller;

  logic clk = 1'b0;
  logic rst, start, msb1, msb2, co1, co2, co3;
  logic ld1, ld2, ld3, shl1, shl2, shl3, cnt1, cnt2, clr_cntr, wr, busy, done;

  int assertCount = 0;
  int failCount   = 0;

  // Output bit order: ld1 ld2 ld3 shl1 shl2 shl3 cnt1 cnt2 clr wr busy done
  localparam logic [11:0] O_NONE  = 12'b000000000000;
  localparam logic [11:0] O_BUSY  = 12'b000000000010;
  localparam logic [11:0] O_LOAD  = 12'b110000001010;
  localparam logic [11:0] O_SHL1  = 12'b000100000010;
  localparam logic [11:0] O_SHL2  = 12'b000010000010;
  localparam logic [11:0] O_MULT  = 12'b001000000010;
  localparam logic [11:0] O_SHIFT = 12'b000001010010;
  localparam logic [11:0] O_WRITE = 12'b000000100110;
  localparam logic [11:0] O_DONE  = 12'b000000000011;

  mult_controller dut (
    .clk(clk), .rst(rst), .start(start), .msb1(msb1), .msb2(msb2),
    .co1(co1), .co2(co2), .co3(co3),
    .ld1(ld1), .ld2(ld2), .ld3(ld3), .shl1(shl1), .shl2(shl2), .shl3(shl3),
    .cnt1(cnt1), .cnt2(cnt2), .clr_cntr(clr_cntr), .wr(wr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, start, msb1, msb2, co1, co2, co3;
    logic [11:0] expOut;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] getOut();
    return {ld1, ld2, ld3, shl1, shl2, shl3, cnt1, cnt2, clr_cntr, wr, busy, done};
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void addVec(logic r, logic s, logic m1, logic m2,
                                 logic c1, logic c2, logic c3, logic [11:0] e);
    vec_t v;
    v.rst = r; v.start = s; v.msb1 = m1; v.msb2 = m2;
    v.co1 = c1; v.co2 = c2; v.co3 = c3; v.expOut = e;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v, input int n);
    rst = v.rst; start = v.start; msb1 = v.msb1; msb2 = v.msb2;
    co1 = v.co1; co2 = v.co2; co3 = v.co3;
    @(negedge clk);
    checkOutput($sformatf("vec%0d", n), getOut(), v.expOut);
    @(posedge clk);
    #1;
  endtask

  // Stand-in datapath: operand RAM, operand registers and the three counters.
  logic [15:0] op1q[16];
  logic [15:0] op2q[16];
  int kq[16];
  int nJobs;
  logic [15:0] r1, r2;
  int nc, pc, idx;
  logic [11:0] s;
  int cWr, cCnt1, cLd1, cLd3, cShl1, cShl2, cShl3, cCnt2, cDone;

  function automatic void driveEnv();
    msb1 = r1[15];
    msb2 = r2[15];
    co3  = (nc >= 16);
    co2  = (idx < 16) && (pc == kq[idx] - 1);
    co1  = (idx == nJobs - 1);
  endfunction

  function automatic void envReset();
    idx = 0; nc = 0; pc = 0; r1 = '0; r2 = '0;
    cWr = 0; cCnt1 = 0; cLd1 = 0; cLd3 = 0; cShl1 = 0;
    cShl2 = 0; cShl3 = 0; cCnt2 = 0; cDone = 0;
    driveEnv();
  endfunction

  task automatic step();
    logic [6:0] pulses;
    @(negedge clk);
    s = getOut();
    pulses = {s[11], s[10], s[9], s[8], s[7], s[6], s[2]};
    assertCount++;
    if (!($countones(pulses) <= 1 || pulses == 7'b1100000)) begin
      failCount++;
      $display("[TB] FAIL exclusive: got %b expected at most one strobe", pulses);
    end
    cLd1 += int'(s[11]); cLd3 += int'(s[9]); cShl1 += int'(s[8]);
    cShl2 += int'(s[7]); cShl3 += int'(s[6]); cCnt1 += int'(s[5]);
    cCnt2 += int'(s[4]); cWr += int'(s[2]); cDone += int'(s[0]);
    @(posedge clk);
    #1;
    if (idx < 16) begin
      if (s[11]) r1 = op1q[idx];
      if (s[10]) r2 = op2q[idx];
    end
    if (s[8]) begin r1 = r1 << 1; nc++; end
    if (s[7]) begin r2 = r2 << 1; nc++; end
    if (s[4]) pc++;
    if (s[3]) begin nc = 0; pc = 0; end
    if (s[5]) idx++;
    driveEnv();
  endtask

  function automatic int clz16(logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 15 - i;
    return 16;
  endfunction

  // mode 0: single start pulse, 1: start held high, 2: random start noise mid-run
  task automatic runJob(input string tag, input int mode);
    int lat, expLat, n1, n2, eShl1, eShl2, eShl3;
    bit seen;
    expLat = 1; eShl1 = 0; eShl2 = 0; eShl3 = 0;
    for (int i = 0; i < nJobs; i++) begin
      n1 = clz16(op1q[i]);
      n2 = clz16(op2q[i]);
      if (n2 > 16 - n1) n2 = 16 - n1;
      expLat += 6 + n1 + n2 + kq[i] - 1;
      eShl1 += n1; eShl2 += n2; eShl3 += kq[i];
    end
    envReset();
    start = 1'b1;
    step();
    if (mode != 1) start = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 3000) begin
      if (mode == 2) start = 1'($urandom_range(0, 1));
      step();
      lat++;
      if (s[0]) seen = 1;
    end
    if (mode != 1) start = 1'b0;
    if (!seen) begin
      failCount++;
      $display("[TB] FAIL %s timeout: got no done expected done", tag);
    end
    checkCount({tag, " latency"}, lat, expLat);
    checkCount({tag, " wr"}, cWr, nJobs);
    checkCount({tag, " cnt1"}, cCnt1, nJobs);
    checkCount({tag, " loads"}, cLd1, nJobs);
    checkCount({tag, " ld3"}, cLd3, nJobs);
    checkCount({tag, " shl1"}, cShl1, eShl1);
    checkCount({tag, " shl2"}, cShl2, eShl2);
    checkCount({tag, " shl3"}, cShl3, eShl3);
    checkCount({tag, " cnt2"}, cCnt2, eShl3);
    checkCount({tag, " done"}, cDone, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 0; msb1 = 0; msb2 = 0; co1 = 0; co2 = 0; co3 = 0;

    // Cycle-by-cycle vectors: a minimal run, a run with shifts, then reset in NORM1
    addVec(1,0,0,0,0,0,0, O_NONE);
    addVec(0,0,0,0,0,0,0, O_NONE);
    addVec(0,1,0,0,0,0,0, O_NONE);
    addVec(0,0,0,0,0,0,0, O_LOAD);
    addVec(0,0,1,1,0,0,0, O_BUSY);
    addVec(0,0,0,1,0,0,0, O_BUSY);
    addVec(0,0,0,0,0,0,0, O_MULT);
    addVec(0,0,0,0,0,1,0, O_SHIFT);
    addVec(0,0,0,0,1,0,0, O_WRITE);
    addVec(0,0,0,0,0,0,0, O_DONE);
    addVec(0,0,0,0,0,0,0, O_NONE);
    addVec(0,1,0,0,0,0,0, O_NONE);
    addVec(0,1,0,0,0,0,0, O_LOAD);
    addVec(0,0,0,0,0,0,0, O_SHL1);
    addVec(0,0,0,0,0,0,1, O_BUSY);
    addVec(0,0,0,0,0,0,0, O_SHL2);
    addVec(0,0,0,0,0,0,1, O_BUSY);
    addVec(0,0,0,0,0,0,0, O_MULT);
    addVec(0,0,0,0,0,0,0, O_SHIFT);
    addVec(0,1,0,0,0,1,0, O_SHIFT);
    addVec(0,0,0,0,0,0,0, O_WRITE);
    addVec(0,0,0,0,0,0,0, O_LOAD);
    addVec(0,0,0,0,0,0,0, O_SHL1);
    addVec(1,0,0,0,0,0,0, O_NONE);
    addVec(0,0,0,0,0,0,0, O_NONE);
    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Both operands already normalised, single result
    nJobs = 1; op1q[0] = 16'h8000; op2q[0] = 16'h8000; kq[0] = 1;
    runJob("minimal", 0);

    // Operand 1 needs 15 shifts, operand 2 none
    nJobs = 1; op1q[0] = 16'h0001; op2q[0] = 16'h8000; kq[0] = 1;
    runJob("shift15", 0);

    // Zero operand: the shift limit must end normalisation
    nJobs = 1; op1q[0] = 16'h0000; op2q[0] = 16'h1234; kq[0] = 2;
    runJob("zeroop", 0);

    // Eight results in one run
    nJobs = 8;
    for (int i = 0; i < 8; i++) begin
      op1q[i] = 16'h8000 >> i; op2q[i] = 16'hC000; kq[i] = 1 + (i % 3);
    end
    runJob("eight", 0);

    // Reset during NORM1 discards the run
    nJobs = 1; op1q[0] = 16'h0001; op2q[0] = 16'h8000; kq[0] = 1;
    envReset();
    start = 1'b1; step(); start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    checkOutput("rstOutputs", s, O_NONE);
    rst = 1'b0;
    step();
    checkOutput("rstIdle", s, O_NONE);
    cWr = 0; cLd1 = 0;
    for (int i = 0; i < 30; i++) step();
    checkCount("rst noWr", cWr, 0);
    checkCount("rst noLoad", cLd1, 0);

    // Start noise mid-run, then start held high across DONE
    nJobs = 2; op1q[0] = 16'h0F00; op2q[0] = 16'h00F0; kq[0] = 3;
    op1q[1] = 16'h8001; op2q[1] = 16'h0003; kq[1] = 4;
    runJob("noise", 2);
    runJob("hold", 1);
    step();
    checkOutput("holdIdleGap", s, O_NONE);
    step();
    checkOutput("holdRestart", s, O_LOAD);
    start = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;

    // Randomised runs
    for (int j = 0; j < 20; j++) begin
      nJobs = $urandom_range(1, 5);
      for (int i = 0; i < nJobs; i++) begin
        op1q[i] = 16'($urandom) >> $urandom_range(0, 15);
        op2q[i] = 16'($urandom) >> $urandom_range(0, 15);
        if ($urandom_range(0, 7) == 0) op1q[i] = '0;
        if ($urandom_range(0, 7) == 0) op2q[i] = '0;
        kq[i] = $urandom_range(1, 4);
      end
      runJob($sformatf("rand%0d", j), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
